// File: rtl/alu181_nibble_seq.sv
// Nibble-serial wide ALU built around one shared 74181 slice.
// Each RUN cycle processes one nibble, LSB first, and registers the slice carry for the next nibble.

module TI74181 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [3:0] i_s,
    input  logic       i_m,
    input  logic       i_cn,
    output logic [3:0] o_f,
    output logic       o_cn1
);
    logic [3:0] w_x;
    logic [3:0] w_y;
    logic [4:0] w_sum;

    // Arithmetic result is X plus Y plus Cn; logic result is XNOR of the same terms.
    always_comb begin
        w_x   = i_a | (i_b & {4{i_s[0]}}) | (~i_b & {4{i_s[1]}});
        w_y   = (i_a & ~i_b & {4{i_s[2]}}) | (i_a & i_b & {4{i_s[3]}});
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, i_cn};
        o_f   = i_m ? ~(w_x ^ w_y) : w_sum[3:0];
        o_cn1 = w_sum[4];
    end
endmodule

module alu181_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4*NIBBLES-1:0] req_a,
    input  logic [4*NIBBLES-1:0] req_b,
    input  logic [3:0]           req_s,
    input  logic                 req_m,
    input  logic                 req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_f,
    output logic                 rsp_cout,
    output logic                 rsp_zero
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [3:0]      r_s;
    logic            r_m;
    logic            r_cin;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_f;

    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic            w_cn;
    logic [3:0]      w_f;
    logic            w_cn1;
    logic [W-1:0]    w_f_next;

    always_comb begin
        w_a_nib = 4'h0;
        w_b_nib = 4'h0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IW'(k)) begin
                w_a_nib = r_a[4*k +: 4];
                w_b_nib = r_b[4*k +: 4];
            end
        end
        w_cn = (r_idx == '0) ? r_cin : r_carry;
    end

    TI74181 u_slice (
        .i_a   (w_a_nib),
        .i_b   (w_b_nib),
        .i_s   (r_s),
        .i_m   (r_m),
        .i_cn  (w_cn),
        .o_f   (w_f),
        .o_cn1 (w_cn1)
    );

    always_comb begin
        w_f_next = r_f;
        for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IW'(k)) begin
                w_f_next[4*k +: 4] = w_f;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        unique case (r_state)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (r_idx == LAST_IDX) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= 4'h0;
            r_m     <= 1'b0;
            r_cin   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_f     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_s     <= req_s;
                        r_m     <= req_m;
                        r_cin   <= req_cin;
                        r_carry <= 1'b0;
                        r_idx   <= '0;
                        r_f     <= '0;
                    end
                end
                StRun: begin
                    r_f     <= w_f_next;
                    r_carry <= w_cn1;
                    // Index parks on the last nibble instead of wrapping.
                    if (r_idx != LAST_IDX) begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_f    = r_f;
    assign rsp_cout = r_m ? 1'b0 : r_carry;
    assign rsp_zero = (r_f == '0);

endmodule

// File: tb/tb_alu181_nibble_seq.sv
// Randomized and directed bench for alu181_nibble_seq against a word-level 74181 function model.

module tb_alu181_nibble_seq;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [3:0]   req_s;
    logic         req_m;
    logic         req_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_f;
    logic         rsp_cout;
    logic         rsp_zero;

    int n_checks = 0;
    int n_pass   = 0;

    alu181_nibble_seq #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_s     (req_s),
        .req_m     (req_m),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_f     (rsp_f),
        .rsp_cout  (rsp_cout),
        .rsp_zero  (rsp_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Datasheet function table evaluated on whole words.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] s, input logic m, input logic cin,
                                  output logic [W-1:0] f, output logic cout);
        logic [W-1:0] ones;
        logic [W-1:0] t1;
        logic [W-1:0] t2;
        logic [W:0]   sum;
        ones = '1;
        t1   = a;
        t2   = '0;
        if (m) begin
            case (s)
                4'h0: f = ~a;
                4'h1: f = ~(a | b);
                4'h2: f = ~a & b;
                4'h3: f = '0;
                4'h4: f = ~(a & b);
                4'h5: f = ~b;
                4'h6: f = a ^ b;
                4'h7: f = a & ~b;
                4'h8: f = ~a | b;
                4'h9: f = ~(a ^ b);
                4'hA: f = b;
                4'hB: f = a & b;
                4'hC: f = ones;
                4'hD: f = a | ~b;
                4'hE: f = a | b;
                default: f = a;
            endcase
            cout = 1'b0;
        end else begin
            case (s)
                4'h0: begin t1 = a;      t2 = '0;     end
                4'h1: begin t1 = a | b;  t2 = '0;     end
                4'h2: begin t1 = a | ~b; t2 = '0;     end
                4'h3: begin t1 = ones;   t2 = '0;     end
                4'h4: begin t1 = a;      t2 = a & ~b; end
                4'h5: begin t1 = a | b;  t2 = a & ~b; end
                4'h6: begin t1 = a;      t2 = ~b;     end
                4'h7: begin t1 = a & ~b; t2 = ones;   end
                4'h8: begin t1 = a;      t2 = a & b;  end
                4'h9: begin t1 = a;      t2 = b;      end
                4'hA: begin t1 = a | ~b; t2 = a & b;  end
                4'hB: begin t1 = a & b;  t2 = ones;   end
                4'hC: begin t1 = a;      t2 = a;      end
                4'hD: begin t1 = a | b;  t2 = a;      end
                4'hE: begin t1 = a | ~b; t2 = a;      end
                default: begin t1 = a;   t2 = ones;   end
            endcase
            sum  = {1'b0, t1} + {1'b0, t2} + {{W{1'b0}}, cin};
            f    = sum[W-1:0];
            cout = sum[W];
        end
    endfunction

    // hold = cycles of rsp_ready low in DONE while new requests are pulsed at the DUT.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic cin, input int hold);
        logic [W-1:0] ef;
        logic         ec;
        int           cyc;
        model(a, b, s, m, cin, ef, ec);
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready before accept", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_s     = s;
        req_m     = m;
        req_cin   = cin;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = W'($urandom);
        req_b     = W'($urandom);
        req_s     = 4'($urandom);
        req_m     = 1'($urandom);
        req_cin   = 1'($urandom);
        cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("latency", 32'(cyc), 32'(NIBBLES));
        check("rsp_f", 32'(rsp_f), 32'(ef));
        check("rsp_cout", 32'(rsp_cout), 32'(ec));
        check("rsp_zero", 32'(rsp_zero), 32'(ef == '0));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_a     = W'($urandom);
            req_b     = W'($urandom);
            req_s     = 4'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp rsp_f", 32'(rsp_f), 32'(ef));
            check("bp rsp_cout", 32'(rsp_cout), 32'(ec));
            check("bp req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("post rsp_valid", 32'(rsp_valid), 32'd0);
        check("post req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_s     = 4'h0;
        req_m     = 1'b0;
        req_cin   = 1'b0;
        rsp_ready = 1'b0;
        #12;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_f", 32'(rsp_f), 32'd0);
        check("reset rsp_cout", 32'(rsp_cout), 32'd0);
        check("reset rsp_zero", 32'(rsp_zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b0, 0);
        check("add f", 32'(rsp_f), 32'h2201);
        check("add cout", 32'(rsp_cout), 32'd0);
        run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 0);
        check("ripple f", 32'(rsp_f), 32'h0000);
        check("ripple cout", 32'(rsp_cout), 32'd1);
        check("ripple zero", 32'(rsp_zero), 32'd1);
        run_op(16'h00FF, 16'h1234, 4'b0000, 1'b0, 1'b1, 0);
        check("incr f", 32'(rsp_f), 32'h0100);
        check("incr cout", 32'(rsp_cout), 32'd0);
        run_op(16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b1, 0);
        check("xor f", 32'(rsp_f), 32'hAA55);
        check("xor cout", 32'(rsp_cout), 32'd0);

        run_op(16'h8001, 16'h7FFF, 4'b1001, 1'b0, 1'b0, 3);
        for (int i = 0; i < NIBBLES + 2; i++) begin
            @(negedge clk);
            check("idle rsp_valid", 32'(rsp_valid), 32'd0);
            check("idle req_ready", 32'(req_ready), 32'd1);
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_a     = 16'h1111;
        req_b     = 16'h1111;
        req_s     = 4'b1001;
        req_m     = 1'b0;
        req_cin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("midrun partial f", 32'(rsp_f), 32'h0022);
        rst_n = 1'b0;
        #1;
        check("midrun rst req_ready", 32'(req_ready), 32'd1);
        check("midrun rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrun rst rsp_f", 32'(rsp_f), 32'd0);
        check("midrun rst rsp_cout", 32'(rsp_cout), 32'd0);
        check("midrun rst rsp_zero", 32'(rsp_zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0003, 16'h0002, 4'b1001, 1'b0, 1'b0, 0);
        check("after rst f", 32'(rsp_f), 32'h0005);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
